// File: rtl/uart_rx_byte.sv
// 16x oversampling UART receiver: 8N1 frames, or 8E1 when UART_RX_PARITY_EN is defined.
// Each good byte is loaded into dataout one clock before a single-cycle datadone strobe.
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       datadone,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic             rx_s1, rx_s2, rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             done_pend;
  logic             fall_c;
  logic             tick_c;
  logic             par_ok_c;

  assign fall_c = rx_prev & ~rx_s2;
  assign tick_c = (state != IDLE) && (div_cnt == DIV_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok_c = ~(^{shreg, par_bit});
`else
  assign par_ok_c   = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Synchroniser, tick divider and frame FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      done_pend <= 1'b0;
      dataout   <= 8'h00;
      datadone  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      frame_err <= 1'b0;
      done_pend <= 1'b0;
      datadone  <= done_pend;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif

      // Divider idles at zero so the first tick lands DIV clocks after the start edge
      if (state == IDLE || tick_c) div_cnt <= '0;
      else                         div_cnt <= div_cnt + DIV_W'(1);

      case (state)
        IDLE: begin
          if (fall_c) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: begin
          if (tick_c) begin
            if (os_cnt == 4'd7) begin
              if (rx_s2) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                os_cnt  <= '0;
                bit_cnt <= '0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick_c) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              shreg   <= {rx_s2, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_c) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              par_bit <= rx_s2;
              state   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick_c) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              state <= IDLE;
              // Framing error wins over parity error
              if (!rx_s2) begin
                frame_err <= 1'b1;
              end else if (par_ok_c) begin
                dataout   <= shreg;
                done_pend <= 1'b1;
              end else begin
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b1;
`endif
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
